// File: rtl/mean_arb_f32.sv
// Round-robin sequencer that shares one mean2_f32 unit among NREQ requesters.
// The unit has no start strobe, so each operation is launched by pulsing its reset.
//
// state   | meaning
// S_IDLE  | look for a request from ptr onward, capture operands of the winner
// S_START | gnt pulse, unit held in reset for one cycle
// S_WAIT  | unit running, count cycles until rdy or timeout
// S_DONE  | done (and err on timeout) pulse to owner, advance ptr

module mean_arb_f32 #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   a_in,
   input  logic [NREQ*WIDTH-1:0]   b_in,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic [NREQ-1:0]         err,
   output logic [WIDTH-1:0]        result,
   output logic                    busy,
   output logic                    u_rst,
   output logic [WIDTH-1:0]        u_a,
   output logic [WIDTH-1:0]        u_b,
   input  logic                    u_rdy,
   input  logic [WIDTH-1:0]        u_mean
);

   localparam int PTR_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [WIDTH-1:0] QNAN = WIDTH'(32'h7FC0_0000);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

   state_t             state;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   owner;
   logic [PTR_W-1:0]   owner_nxt;
   logic [PTR_W-1:0]   pick;
   logic               found;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   sel_a;
   logic [WIDTH-1:0]   sel_b;

   // Two passes avoid a modulo index: indices at or above ptr first, then wrap to the lowest.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[i] && (PTR_W'(i) >= ptr)) begin
            found = 1'b1;
            pick  = PTR_W'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[i]) begin
            found = 1'b1;
            pick  = PTR_W'(i);
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (PTR_W'(i) == pick) begin
            sel_a = a_in[i*WIDTH +: WIDTH];
            sel_b = b_in[i*WIDTH +: WIDTH];
         end
      end
   end

   assign owner_nxt = (owner == PTR_W'(NREQ-1)) ? '0 : owner + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         ptr    <= '0;
         owner  <= '0;
         gnt    <= '0;
         done   <= '0;
         err    <= '0;
         result <= '0;
         u_a    <= '0;
         u_b    <= '0;
         busy   <= 1'b0;
         cnt    <= '0;
      end else begin
         gnt  <= '0;
         done <= '0;
         err  <= '0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  u_a   <= sel_a;
                  u_b   <= sel_b;
                  owner <= pick;
                  gnt   <= NREQ'(1) << pick;
                  busy  <= 1'b1;
                  state <= S_START;
               end
            end
            S_START: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               // rdy takes priority over a timeout landing on the same cycle
               if (u_rdy) begin
                  result <= u_mean;
                  done   <= NREQ'(1) << owner;
                  state  <= S_DONE;
               end else if (cnt == CNT_W'(TIMEOUT-1)) begin
                  result <= QNAN;
                  done   <= NREQ'(1) << owner;
                  err    <= NREQ'(1) << owner;
                  state  <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               ptr   <= owner_nxt;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign u_rst = rst | (state == S_START);

endmodule

// File: tb/tb_mean_arb_f32.sv
// Bench for mean_arb_f32: a transaction-schedule reference model predicts every output each cycle,
// directed scenarios add literal expectations, then a long randomized run.

module tb_mean_arb_f32;
   localparam int NREQ    = 4;
   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 64;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in;
   logic [NREQ*WIDTH-1:0] b_in;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic [NREQ-1:0]       err;
   logic [WIDTH-1:0]      result;
   logic                  busy;
   logic                  u_rst;
   logic [WIDTH-1:0]      u_a;
   logic [WIDTH-1:0]      u_b;
   logic                  u_rdy;
   logic [WIDTH-1:0]      u_mean;

   mean_arb_f32 #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
      .u_rst(u_rst), .u_a(u_a), .u_b(u_b), .u_rdy(u_rdy), .u_mean(u_mean)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model: architectural registers plus the schedule of the transaction in flight
   int               m_ptr = 0;
   logic [WIDTH-1:0] m_ua = '0, m_ub = '0, m_result = '0;
   bit               tr_active = 0;
   int               tr_t, tr_owner, tr_k, tr_done;
   bit               tr_err;
   logic [WIDTH-1:0] tr_mean;

   int               next_k = -1;
   bit               use_mean = 0;
   logic [WIDTH-1:0] next_mean;
   int               gnt_log[$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   function automatic int rr_pick(logic [NREQ-1:0] r, int p);
      for (int i = 0; i < NREQ; i++)
         if (r[(p + i) % NREQ]) return (p + i) % NREQ;
      return -1;
   endfunction

   function automatic int rand_k();
      int r;
      r = $urandom_range(0, 9);
      case (r)
         0:       return TIMEOUT - 1;
         1:       return TIMEOUT - 2;
         2:       return 1000;
         default: return $urandom_range(0, 6);
      endcase
   endfunction

   // unit stand-in: rdy rises k cycles into WAIT; outside WAIT rdy/mean are noise
   task automatic drive_unit();
      if (tr_active && cyc >= tr_t + 2 && cyc < tr_done) begin
         u_rdy  = (cyc >= tr_t + 2 + tr_k);
         u_mean = (cyc == tr_t + 2 + tr_k) ? tr_mean : $urandom;
      end else begin
         u_rdy  = 1'($urandom_range(0, 1));
         u_mean = $urandom;
      end
   endtask

   task automatic model_update();
      bit was_idle;
      if (rst) begin
         tr_active = 0;
         m_ptr     = 0;
         m_ua      = '0;
         m_ub      = '0;
         m_result  = '0;
      end else begin
         was_idle = !tr_active;
         if (tr_active && cyc == tr_done - 1)
            m_result = tr_err ? 32'h7FC0_0000 : tr_mean;
         if (tr_active && cyc == tr_done) begin
            m_ptr     = (tr_owner + 1) % NREQ;
            tr_active = 0;
         end
         if (was_idle && req != '0) begin
            tr_owner  = rr_pick(req, m_ptr);
            tr_t      = cyc;
            tr_active = 1;
            tr_k      = (next_k >= 0) ? next_k : rand_k();
            next_k    = -1;
            tr_mean   = use_mean ? next_mean : $urandom;
            use_mean  = 0;
            tr_err    = (tr_k > TIMEOUT - 1);
            tr_done   = tr_err ? tr_t + 2 + TIMEOUT : tr_t + 3 + tr_k;
            m_ua      = a_in[tr_owner*WIDTH +: WIDTH];
            m_ub      = b_in[tr_owner*WIDTH +: WIDTH];
         end
      end
   endtask

   task automatic compare();
      logic [NREQ-1:0] eg, ed, ee;
      bit in_start, in_done;
      in_start = tr_active && (cyc == tr_t + 1);
      in_done  = tr_active && (cyc == tr_done);
      eg = in_start ? NREQ'(1) << tr_owner : '0;
      ed = in_done  ? NREQ'(1) << tr_owner : '0;
      ee = (in_done && tr_err) ? NREQ'(1) << tr_owner : '0;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("done", 32'(done), 32'(ed));
      chk("err", 32'(err), 32'(ee));
      chk("busy", 32'(busy), 32'(tr_active));
      chk("result", result, m_result);
      chk("u_a", u_a, m_ua);
      chk("u_b", u_b, m_ub);
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) gnt_log.push_back(i);
   endtask

   task automatic step();
      drive_unit();
      #1;
      chk("u_rst", 32'(u_rst), 32'(rst | (tr_active && cyc == tr_t + 1)));
      @(posedge clk);
      model_update();
      cyc++;
      #1;
      compare();
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      req = '0;
      repeat (2) step();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_order[5];
      int budget;
      rst    = 1'b1;
      req    = '0;
      a_in   = '0;
      b_in   = '0;
      u_rdy  = 1'b0;
      u_mean = '0;
      @(negedge clk);

      // reset state
      reset_dut();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_gnt", 32'(gnt), 32'd0);

      // single request: 3.0 and 5.0, unit ready 5 cycles after the u_rst pulse
      a_in[0 +: 32] = 32'h4040_0000;
      b_in[0 +: 32] = 32'h40A0_0000;
      req = 4'b0001; next_k = 4; use_mean = 1; next_mean = 32'h4080_0000;
      step();
      chk("single_gnt", 32'(gnt), 32'h1);
      req = '0;
      repeat (6) step();
      chk("single_done", 32'(done), 32'h1);
      chk("single_err", 32'(err), 32'h0);
      chk("single_result", result, 32'h4080_0000);
      chk("single_ua", u_a, 32'h4040_0000);
      step();
      chk("single_busy", 32'(busy), 32'd0);

      // round-robin with every request held
      reset_dut();
      gnt_log.delete();
      req = 4'b1111;
      budget = 0;
      while (gnt_log.size() < 5 && budget < 1000) begin
         step();
         budget++;
      end
      req = '0;
      exp_order = '{0, 1, 2, 3, 0};
      if (gnt_log.size() < 5) chk("rr_bound", 32'(gnt_log.size()), 32'd5);
      else for (int i = 0; i < 5; i++) chk("rr_order", 32'(gnt_log[i]), 32'(exp_order[i]));
      repeat (200) step();

      // timeout on requester 2, then a normal request
      reset_dut();
      req = 4'b0100; next_k = 1000;
      step();
      chk("to_gnt", 32'(gnt), 32'h4);
      req = '0;
      repeat (64) step();
      chk("to_early", 32'(done), 32'h0);
      step();
      chk("to_done", 32'(done), 32'h4);
      chk("to_err", 32'(err), 32'h4);
      chk("to_result", result, 32'h7FC0_0000);
      step();
      req = 4'b0001; next_k = 2; use_mean = 1; next_mean = 32'h3FC0_0000;
      step();
      req = '0;
      repeat (4) step();
      chk("after_to_done", 32'(done), 32'h1);
      chk("after_to_err", 32'(err), 32'h0);
      chk("after_to_result", result, 32'h3FC0_0000);

      // rdy on the very cycle the timeout would fire
      reset_dut();
      req = 4'b0001; next_k = TIMEOUT - 1; use_mean = 1; next_mean = 32'h3F80_0000;
      step();
      req = '0;
      repeat (65) step();
      chk("tie_done", 32'(done), 32'h1);
      chk("tie_err", 32'(err), 32'h0);
      chk("tie_result", result, 32'h3F80_0000);

      // reset three cycles into WAIT abandons the operation and clears ptr
      reset_dut();
      req = 4'b0100; next_k = 20;
      step();
      req = '0;
      repeat (4) step();
      rst = 1'b1;
      req = 4'b1010;
      #1;
      chk("midrst_urst", 32'(u_rst), 32'd1);
      step();
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'h0);
      rst = 1'b0;
      step();
      chk("midrst_gnt", 32'(gnt), 32'h2);
      req = '0;
      repeat (30) step();

      // operands held after grant even if inputs change and req drops
      reset_dut();
      a_in[2*32 +: 32] = 32'h4120_0000;
      b_in[2*32 +: 32] = 32'h41A0_0000;
      req = 4'b0100; next_k = 4; use_mean = 1; next_mean = 32'h4170_0000;
      step();
      req  = '0;
      a_in = {$urandom, $urandom, $urandom, $urandom};
      b_in = {$urandom, $urandom, $urandom, $urandom};
      repeat (6) step();
      chk("stab_done", 32'(done), 32'h4);
      chk("stab_ua", u_a, 32'h4120_0000);
      chk("stab_ub", u_b, 32'h41A0_0000);
      chk("stab_result", result, 32'h4170_0000);

      // randomized traffic with occasional resets
      reset_dut();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
         a_in = {$urandom, $urandom, $urandom, $urandom};
         b_in = {$urandom, $urandom, $urandom, $urandom};
         rst  = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;
      req = '0;
      repeat (80) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
